oam_dma: RTL and testbench

// - OAM sprite DMA engine. Sits directly upstream of the PPU register file on the CPU bus.
// - A CPU write to $4014 with page P stalls the CPU through dma_hijack.
// - It then copies CPU bytes $PP00-$PPFF, one at a time, into the PPU OAMDATA port ($2004).
// - The PPU's existing $2004 write path stores each byte at OAM_ADDR and post-increments OAM_ADDR.

---
 rtl/oam_dma.sv | 158 +++++++++++++++
 tb/tb_oam_dma.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// OamDma (module oam_dma)
//
// Purpose:
//   OAM sprite DMA engine sitting in front of the PPU register file on the
//   CPU bus. A CPU write of page P to DMA_REG_ADDR stalls the CPU (hijack)
//   and copies bytes $PP00..$PP(XFER_LEN-1) one at a time into the PPU
//   OAMDATA port. Each byte takes a READ cycle (source address on the bus)
//   followed by a WRITE cycle (synchronous RAM data forwarded to OAMDATA).
//
// Configuration macro:
//   OAM_DMA_ALIGN_EN - when defined, a transfer whose ALIGN cycle falls on an
//                      odd CPU cycle spends one extra dummy cycle (ALIGN2)
//                      before the first read. When undefined, ALIGN always
//                      goes straight to READ.
//
// Ports:
//   i_cpu_clk      CPU-domain clock, all state changes on its rising edge
//   i_reset        synchronous active-high reset
//   i_bus_addr     CPU bus address (meaningful while o_dma_hijack = 0)
//   i_bus_din      CPU write data (page number on a trigger write)
//   i_bus_wr       CPU write strobe
//   i_odd_or_even  CPU cycle parity, 1 = odd cycle
//   i_cpu_rdata    system read data, valid the cycle after the address
//   o_dma_hijack   1 = DMA owns the bus, CPU stalled
//   o_dma_addr     DMA bus address (0 while not hijacking)
//   o_dma_dout     DMA write data (0 while not writing)
//   o_dma_wr       DMA write strobe
//   o_dma_done     one-cycle pulse the cycle after the final OAM write
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        i_cpu_clk,
    input  logic        i_reset,
    input  logic [15:0] i_bus_addr,
    input  logic [7:0]  i_bus_din,
    input  logic        i_bus_wr,
    input  logic        i_odd_or_even,
    input  logic [7:0]  i_cpu_rdata,
    output logic        o_dma_hijack,
    output logic [15:0] o_dma_addr,
    output logic [7:0]  o_dma_dout,
    output logic        o_dma_wr,
    output logic        o_dma_done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ALIGN2,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic       w_trigger;
    logic       w_lastByte;

    // A trigger is only honoured from IDLE; writes seen during a transfer
    // or in the DONE cycle fall through without effect.
    assign w_trigger  = (r_state == S_IDLE) && i_bus_wr && (i_bus_addr == DMA_REG_ADDR);
    assign w_lastByte = (r_idx == LAST_IDX);

`ifndef OAM_DMA_ALIGN_EN
    // Parity only matters for the optional alignment cycle.
    logic w_unusedParity;
    assign w_unusedParity = i_odd_or_even;
`endif

    // State register.
    always_ff @(posedge i_cpu_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Page latch and byte index. The index is 8 bits wide so the source
    // address wraps within the page and never carries into page+1.
    always_ff @(posedge i_cpu_clk) begin
        if (i_reset) begin
            r_page <= 8'h00;
            r_idx  <= 8'h00;
        end else if (w_trigger) begin
            r_page <= i_bus_din;
            r_idx  <= 8'h00;
        end else if ((r_state == S_WRITE) && !w_lastByte) begin
            r_idx <= r_idx + 8'h01;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_nextState = S_ALIGN;
                end
            end
            S_ALIGN: begin
`ifdef OAM_DMA_ALIGN_EN
                w_nextState = i_odd_or_even ? S_ALIGN2 : S_READ;
`else
                w_nextState = S_READ;
`endif
            end
            S_ALIGN2: w_nextState = S_READ;
            S_READ:   w_nextState = S_WRITE;
            S_WRITE:  w_nextState = w_lastByte ? S_DONE : S_READ;
            S_DONE:   w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Output decode. The data to write arrives from the synchronous RAM
    // during WRITE, one cycle after READ presented the source address, so
    // it is forwarded combinationally rather than re-registered.
    always_comb begin
        o_dma_hijack = 1'b0;
        o_dma_addr   = 16'h0000;
        o_dma_dout   = 8'h00;
        o_dma_wr     = 1'b0;
        o_dma_done   = 1'b0;
        case (r_state)
            S_ALIGN, S_ALIGN2: begin
                o_dma_hijack = 1'b1;
            end
            S_READ: begin
                o_dma_hijack = 1'b1;
                o_dma_addr   = {r_page, r_idx};
            end
            S_WRITE: begin
                o_dma_hijack = 1'b1;
                o_dma_addr   = OAM_DATA_ADDR;
                o_dma_dout   = i_cpu_rdata;
                o_dma_wr     = 1'b1;
            end
            S_DONE: begin
                o_dma_done = 1'b1;
            end
            default: begin
                o_dma_hijack = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// TbOamDma (module tb_oam_dma)
//
// Bench for oam_dma. A synchronous RAM model supplies read data; a monitor
// on the falling edge tallies hijack cycles, reads, writes and done pulses
// for the current transfer and accumulates address/data errors against a
// reference RAM content function. Directed scenarios then compare those
// tallies with hand-derived values.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] busAddr = 16'h0000;
    logic [7:0]  busDin = 8'h00;
    logic        busWr = 1'b0;
    logic        oddOrEven = 1'b0;
    logic [7:0]  cpuRdata = 8'h00;
    logic        dmaHijack;
    logic [15:0] dmaAddr;
    logic [7:0]  dmaDout;
    logic        dmaWr;
    logic        dmaDone;

    int numChecks = 0;
    int numPassed = 0;

    logic [7:0] expPage = 8'h02;

    // Monitor tallies, cleared whenever the CPU writes while not stalled.
    int          hijackCycles = 0;
    int          readCount = 0;
    int          writeCount = 0;
    int          doneCount = 0;
    int          readAddrErrors = 0;
    int          writeAddrErrors = 0;
    int          dataErrors = 0;
    int          seqErrors = 0;
    int          idleDriveErrors = 0;
    logic        prevWasRead = 1'b0;
    logic [15:0] lastReadAddr = 16'h0000;
    logic [7:0]  firstByte = 8'h00;
    logic [7:0]  secondByte = 8'h00;

    oam_dma dut (
        .i_cpu_clk     (clock),
        .i_reset       (reset),
        .i_bus_addr    (busAddr),
        .i_bus_din     (busDin),
        .i_bus_wr      (busWr),
        .i_odd_or_even (oddOrEven),
        .i_cpu_rdata   (cpuRdata),
        .o_dma_hijack  (dmaHijack),
        .o_dma_addr    (dmaAddr),
        .o_dma_dout    (dmaDout),
        .o_dma_wr      (dmaWr),
        .o_dma_done    (dmaDone)
    );

    always #5 clock = ~clock;

    // Memory content: page $02 holds i ^ $A5, other pages differ by page offset.
    function automatic logic [7:0] ramValue(input logic [15:0] addr);
        return addr[7:0] ^ 8'hA5 ^ (addr[15:8] - 8'h02);
    endfunction

    // Synchronous RAM: data for the address seen at an edge is valid after it.
    always @(posedge clock) begin
        cpuRdata <= ramValue(dmaHijack ? dmaAddr : busAddr);
    end

    // Falling-edge monitor of DMA bus activity.
    always @(negedge clock) begin
        if (busWr && !dmaHijack) begin
            hijackCycles    = 0;
            readCount       = 0;
            writeCount      = 0;
            doneCount       = 0;
            readAddrErrors  = 0;
            writeAddrErrors = 0;
            dataErrors      = 0;
            seqErrors       = 0;
            idleDriveErrors = 0;
            prevWasRead     = 1'b0;
            lastReadAddr    = 16'h0000;
            firstByte       = 8'h00;
            secondByte      = 8'h00;
        end else begin
            if (dmaHijack) begin
                hijackCycles++;
            end
            if (!dmaHijack && (dmaWr || dmaAddr != 16'h0000 || dmaDout != 8'h00)) begin
                idleDriveErrors++;
            end
            if (dmaHijack && !dmaWr && dmaAddr != 16'h0000) begin
                if (dmaAddr != {expPage, 8'(readCount)}) begin
                    readAddrErrors++;
                end
                if (prevWasRead) begin
                    seqErrors++;
                end
                prevWasRead  = 1'b1;
                lastReadAddr = dmaAddr;
                readCount++;
            end
            if (dmaWr) begin
                if (dmaAddr != 16'h2004) begin
                    writeAddrErrors++;
                end
                if (!prevWasRead) begin
                    seqErrors++;
                end
                prevWasRead = 1'b0;
                if (dmaDout != ramValue({expPage, 8'(writeCount)})) begin
                    dataErrors++;
                end
                if (writeCount == 0) begin
                    firstByte = dmaDout;
                end
                if (writeCount == 1) begin
                    secondByte = dmaDout;
                end
                writeCount++;
            end
            if (dmaDone) begin
                doneCount++;
            end
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed === expected) begin
            numPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle of CPU bus activity, then the bus returns quiet.
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] din,
                                 input logic wr);
        @(posedge clock);
        #1;
        busAddr = addr;
        busDin  = din;
        busWr   = wr;
        @(posedge clock);
        #1;
        busAddr = 16'h0000;
        busDin  = 8'h00;
        busWr   = 1'b0;
    endtask

    // Bounded wait for the done pulse plus a few settling cycles.
    task automatic waitDone(input string tag, input int budget);
        int cyc = 0;
        while (doneCount == 0 && cyc < budget) begin
            @(posedge clock);
            cyc++;
        end
        repeat (4) @(posedge clock);
        #1;
        checkOutput({tag, ".doneCount"}, doneCount, 1);
    endtask

    task automatic checkFullTransfer(input string tag, input int expHijack);
        checkOutput({tag, ".hijackCycles"}, hijackCycles, expHijack);
        checkOutput({tag, ".writeCount"}, writeCount, 256);
        checkOutput({tag, ".readCount"}, readCount, 256);
        checkOutput({tag, ".dataErrors"}, dataErrors, 0);
        checkOutput({tag, ".readAddrErrors"}, readAddrErrors, 0);
        checkOutput({tag, ".writeAddrErrors"}, writeAddrErrors, 0);
        checkOutput({tag, ".seqErrors"}, seqErrors, 0);
        checkOutput({tag, ".idleDriveErrors"}, idleDriveErrors, 0);
        checkOutput({tag, ".lastReadAddr"}, lastReadAddr, {expPage, 8'hFF});
        checkOutput({tag, ".hijackAfter"}, dmaHijack, 0);
    endtask

    initial begin
        int oddExpected;
        int cyc;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset.hijack", dmaHijack, 0);
        checkOutput("reset.wr", dmaWr, 0);
        checkOutput("reset.addr", dmaAddr, 0);
        checkOutput("reset.dout", dmaDout, 0);
        checkOutput("reset.done", dmaDone, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Page $02 on an even cycle: $A5, $A4, ... over 513 hijack cycles.
        $display("[TB] page 02 even-cycle transfer");
        expPage   = 8'h02;
        oddOrEven = 1'b0;
        applyStimulus(16'h4014, 8'h02, 1'b1);
        #1;
        checkOutput("even.hijackRise", dmaHijack, 1);
        waitDone("even", 600);
        checkFullTransfer("even", 513);
        checkOutput("even.firstByte", firstByte, 8'hA5);
        checkOutput("even.secondByte", secondByte, 8'hA4);

        // Odd-cycle trigger: one extra align cycle only with the macro.
`ifdef OAM_DMA_ALIGN_EN
        oddExpected = 514;
`else
        oddExpected = 513;
`endif
        $display("[TB] page 05 odd-cycle transfer");
        expPage   = 8'h05;
        oddOrEven = 1'b1;
        applyStimulus(16'h4014, 8'h05, 1'b1);
        waitDone("odd", 600);
        checkFullTransfer("odd", oddExpected);
        oddOrEven = 1'b0;

        // Page $FF wraps within the page and ends at $FFFF.
        $display("[TB] page FF transfer");
        expPage = 8'hFF;
        applyStimulus(16'h4014, 8'hFF, 1'b1);
        waitDone("pageFF", 600);
        checkFullTransfer("pageFF", 513);

        // Retrigger to page $03 mid-transfer must be ignored.
        $display("[TB] retrigger during transfer");
        expPage = 8'h02;
        applyStimulus(16'h4014, 8'h02, 1'b1);
        repeat (50) @(posedge clock);
        applyStimulus(16'h4014, 8'h03, 1'b1);
        waitDone("retrig", 600);
        checkFullTransfer("retrig", 513);

        // Reset after the 100th OAM write aborts cleanly with no done pulse.
        $display("[TB] reset mid-transfer");
        expPage = 8'h07;
        applyStimulus(16'h4014, 8'h07, 1'b1);
        cyc = 0;
        while (writeCount < 100 && cyc < 400) begin
            @(posedge clock);
            cyc++;
        end
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abort.hijack", dmaHijack, 0);
        checkOutput("abort.wr", dmaWr, 0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("abort.writeCount", writeCount, 100);
        checkOutput("abort.doneCount", doneCount, 0);
        checkOutput("abort.hijackIdle", dmaHijack, 0);
        applyStimulus(16'h4014, 8'h07, 1'b1);
        waitDone("restart", 600);
        checkFullTransfer("restart", 513);

        // Neighbouring register write and a read of $4014 start nothing.
        $display("[TB] non-trigger accesses");
        applyStimulus(16'h4015, 8'h02, 1'b1);
        applyStimulus(16'h4014, 8'h02, 1'b0);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("noTrig.hijackCycles", hijackCycles, 0);
        checkOutput("noTrig.writeCount", writeCount, 0);
        checkOutput("noTrig.doneCount", doneCount, 0);
        checkOutput("noTrig.hijack", dmaHijack, 0);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
